// File: rtl/layer3_window_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : layer3_window_gen_if
//  Brief    : Element-stream input and 3x3-window output bundle for the window generator.
//  Revision : 1.0
// ============================================================================
interface layer3_window_gen_if #(
    parameter int DATA_W = 128
);
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [9*DATA_W-1:0] out_win;
    logic                out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_win, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_win, out_last
    );
endinterface
`default_nettype wire

// File: rtl/layer3_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : layer3_window_gen
//  Brief    : Sliding 3x3 window generator over a square row-major feature map.
//  Revision : 1.0
// ============================================================================
module layer3_window_gen #(
    parameter int DATA_W  = 128,
    parameter int ROW_LEN = 14
) (
    input  wire logic          clk,
    input  wire logic          rst,
    layer3_window_gen_if.slave bus
);
    localparam int                 c_CNT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(ROW_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_TWO   = c_CNT_W'(2);

    logic [DATA_W-1:0]   r_dl1 [ROW_LEN];
    logic [DATA_W-1:0]   r_dl2 [ROW_LEN];
    logic [DATA_W-1:0]   r_tap [3][3];
    logic [c_CNT_W-1:0]  r_col;
    logic [c_CNT_W-1:0]  r_row;
    logic                r_out_valid;
    logic                r_out_last;

    logic                w_accept;
    logic                w_produce;
    logic                w_last_pos;
    logic [DATA_W-1:0]   w_dl1_out;
    logic [DATA_W-1:0]   w_dl2_out;
    logic [9*DATA_W-1:0] w_win;

    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_dl1_out     = r_dl1[ROW_LEN-1];
    assign w_dl2_out     = r_dl2[ROW_LEN-1];
    assign w_produce     = (r_row >= c_TWO) && (r_col >= c_TWO);
    assign w_last_pos    = (r_row == c_LAST) && (r_col == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == c_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffers carry over frame seams; windows touching old rows are never produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROW_LEN; i++) begin
                r_dl1[i] <= '0;
                r_dl2[i] <= '0;
            end
        end else if (w_accept) begin
            r_dl1[0] <= bus.in_data;
            r_dl2[0] <= w_dl1_out;
            for (int i = 1; i < ROW_LEN; i++) begin
                r_dl1[i] <= r_dl1[i-1];
                r_dl2[i] <= r_dl2[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_tap[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_tap[i][0] <= r_tap[i][1];
                r_tap[i][1] <= r_tap[i][2];
            end
            r_tap[0][2] <= w_dl2_out;
            r_tap[1][2] <= w_dl1_out;
            r_tap[2][2] <= bus.in_data;
        end
    end

    // Taps only move on accept, and accept is blocked while a window stalls,
    // so the tap array itself serves as the held output window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept && w_produce) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_pos;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    always_comb begin
        w_win = '0;
        for (int k = 0; k < 9; k++) begin
            w_win[k*DATA_W +: DATA_W] = r_tap[k/3][k%3];
        end
    end

    assign bus.out_win   = w_win;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
endmodule
`default_nettype wire

// File: tb/tb_layer3_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer3_window_gen
//  Brief    : Self-checking bench for layer3_window_gen against a frame-memory window model.
//  Revision : 1.0
// ============================================================================
module tb_layer3_window_gen;
    localparam int DATA_W  = 128;
    localparam int ROW_LEN = 14;
    localparam int N_ELEM  = ROW_LEN * ROW_LEN;
    localparam int N_WIN   = (ROW_LEN - 2) * (ROW_LEN - 2);

    typedef logic [9*DATA_W-1:0] win_t;
    typedef struct {
        win_t win;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    layer3_window_gen_if #(.DATA_W(DATA_W)) bus ();

    layer3_window_gen #(.DATA_W(DATA_W), .ROW_LEN(ROW_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the current frame kept as a flat array indexed by position.
    logic [DATA_W-1:0] m_frame [N_ELEM];
    int                m_pos;
    exp_t              m_q [$];

    logic s_hs, s_acc, s_valid, s_last, s_in_ready, s_exp_ok, s_exp_last;
    win_t s_win, s_exp_win;

    function automatic string win_str(input win_t w);
        string s = "";
        for (int k = 0; k < 9; k++) s = {s, $sformatf("%0d ", w[k*DATA_W +: 32])};
        return s;
    endfunction

    function automatic win_t lit_win(input int r0, input int c0, input int base);
        win_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*DATA_W +: DATA_W] = DATA_W'(base + (r0 + i) * ROW_LEN + c0 + j);
        return w;
    endfunction

    function automatic void model_accept(input logic [DATA_W-1:0] v);
        int   r, c;
        exp_t e;
        m_frame[m_pos] = v;
        r = m_pos / ROW_LEN;
        c = m_pos % ROW_LEN;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[(3*i+j)*DATA_W +: DATA_W] = m_frame[(r - 2 + i) * ROW_LEN + (c - 2 + j)];
            e.last = (m_pos == N_ELEM - 1);
            m_q.push_back(e);
        end
        m_pos = (m_pos + 1) % N_ELEM;
    endfunction

    // Drive one cycle of inputs, sample the DUT mid-cycle, advance the model.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic ordy, input logic r);
        exp_t e;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        rst           = r;
        @(negedge clk);
        s_valid    = bus.out_valid;
        s_last     = bus.out_last;
        s_win      = bus.out_win;
        s_in_ready = bus.in_ready;
        s_hs       = bus.out_valid && bus.out_ready && !r;
        s_acc      = bus.in_valid && bus.in_ready && !r;
        s_exp_ok   = 1'b0;
        if (r) begin
            m_q.delete();
            m_pos = 0;
        end else begin
            if (s_hs && m_q.size() > 0) begin
                e          = m_q.pop_front();
                s_exp_ok   = 1'b1;
                s_exp_win  = e.win;
                s_exp_last = e.last;
            end
            if (s_acc) model_accept(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'(($urandom % 2)), DATA_W'($urandom), 1'(($urandom % 2)), 1'b1);
        step(1'b1, DATA_W'($urandom), 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (s_valid !== 1'b0 || s_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b last=%b, expected 0 0", s_valid, s_last);
        end
        checks++;
        if (s_win !== '0) begin
            errors++;
            $display("FAIL reset_win: got [%s], expected all zero", win_str(s_win));
        end
        checks++;
        if (s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", s_in_ready);
        end
    endtask

    task automatic test_stream(input int nframes, input bit do_reset, input string tag);
        int   total = nframes * N_ELEM;
        int   sent = 0, nwin = 0, nlast = 0, b2b = 0, acc30 = -1, first = -1, f;
        bit   prev_valid = 1'b0, done = 1'b0;
        win_t prev_win = '0;
        if (do_reset) step(1'b0, '0, 1'b1, 1'b1);
        for (int cyc = 0; cyc < total + 64; cyc++) begin
            if (sent >= total && m_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
            step(sent < total, DATA_W'(sent), 1'b1, 1'b0);
            if (s_valid && prev_valid && s_win !== prev_win) b2b++;
            prev_valid = s_valid;
            prev_win   = s_win;
            if (s_valid && first < 0) first = cyc;
            if (s_hs) begin
                f = nwin / N_WIN;
                checks++;
                if (!s_exp_ok || s_win !== s_exp_win || s_last !== s_exp_last) begin
                    errors++;
                    $display("FAIL %s_window %0d: got [%s] last=%b, expected [%s] last=%b queued=%b",
                             tag, nwin, win_str(s_win), s_last, win_str(s_exp_win), s_exp_last, s_exp_ok);
                end
                if (nwin % N_WIN == 0) begin
                    checks++;
                    if (s_win !== lit_win(0, 0, f * N_ELEM)) begin
                        errors++;
                        $display("FAIL %s_first_window frame %0d: got [%s], expected [%s]",
                                 tag, f, win_str(s_win), win_str(lit_win(0, 0, f * N_ELEM)));
                    end
                end
                if (s_last) begin
                    nlast++;
                    checks++;
                    if (s_win[8*DATA_W +: DATA_W] !== DATA_W'((f + 1) * N_ELEM - 1)) begin
                        errors++;
                        $display("FAIL %s_last_pos: got bottom-right %0d, expected %0d",
                                 tag, s_win[8*DATA_W +: 32], (f + 1) * N_ELEM - 1);
                    end
                end
                nwin++;
            end
            if (s_acc) begin
                if (sent == 30) acc30 = cyc;
                sent++;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: sent %0d of %0d, pending %0d", tag, sent, total, m_q.size());
        end
        checks++;
        if (nwin != nframes * N_WIN) begin
            errors++;
            $display("FAIL %s_count: got %0d windows, expected %0d", tag, nwin, nframes * N_WIN);
        end
        checks++;
        if (nlast != nframes) begin
            errors++;
            $display("FAIL %s_last_count: got %0d, expected %0d", tag, nlast, nframes);
        end
        checks++;
        if (first != acc30 + 1) begin
            errors++;
            $display("FAIL %s_latency: first valid at cycle %0d, expected %0d", tag, first, acc30 + 1);
        end
        checks++;
        if (b2b != nframes * (ROW_LEN - 2) * (ROW_LEN - 3)) begin
            errors++;
            $display("FAIL %s_throughput: got %0d back-to-back updates, expected %0d",
                     tag, b2b, nframes * (ROW_LEN - 2) * (ROW_LEN - 3));
        end
    endtask

    task automatic test_stall;
        int   sent = 0, nwin = 0, stall_left = 5;
        bit   done = 1'b0;
        logic ordy;
        step(1'b0, '0, 1'b1, 1'b1);
        for (int cyc = 0; cyc < N_ELEM + 64; cyc++) begin
            if (sent >= N_ELEM && m_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
            ordy = !(nwin == 2 && bus.out_valid && stall_left > 0);
            if (!ordy) stall_left--;
            step(sent < N_ELEM, DATA_W'(sent), ordy, 1'b0);
            if (!ordy) begin
                checks++;
                if (s_valid !== 1'b1 || s_last !== 1'b0 || s_in_ready !== 1'b0 || s_win !== lit_win(0, 2, 0)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b last=%b in_ready=%b [%s], expected 1 0 0 [%s]",
                             s_valid, s_last, s_in_ready, win_str(s_win), win_str(lit_win(0, 2, 0)));
                end
            end
            if (s_hs) begin
                checks++;
                if (!s_exp_ok || s_win !== s_exp_win || s_last !== s_exp_last) begin
                    errors++;
                    $display("FAIL stall_window %0d: got [%s] last=%b, expected [%s] last=%b queued=%b",
                             nwin, win_str(s_win), s_last, win_str(s_exp_win), s_exp_last, s_exp_ok);
                end
                nwin++;
            end
            if (s_acc) sent++;
        end
        checks++;
        if (!done || stall_left != 0) begin
            errors++;
            $display("FAIL stall_timeout: done=%b stall cycles left %0d, expected 1 0", done, stall_left);
        end
        checks++;
        if (nwin != N_WIN) begin
            errors++;
            $display("FAIL stall_count: got %0d windows, expected %0d", nwin, N_WIN);
        end
    endtask

    task automatic test_gaps;
        int   sent = 0, nwin = 0;
        bit   done = 1'b0, prev_stall = 1'b0;
        logic v, ordy, prev_last = 1'b0;
        win_t prev_win = '0;
        step(1'b0, '0, 1'b1, 1'b1);
        for (int cyc = 0; cyc < 8 * N_ELEM; cyc++) begin
            if (sent >= N_ELEM && m_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
            v    = (sent < N_ELEM) && ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 3) != 0);
            step(v, v ? DATA_W'(sent) : DATA_W'($urandom), ordy, 1'b0);
            checks++;
            if (s_in_ready !== (!s_valid || ordy)) begin
                errors++;
                $display("FAIL gaps_in_ready: got %b, expected %b", s_in_ready, !s_valid || ordy);
            end
            if (prev_stall) begin
                checks++;
                if (s_valid !== 1'b1 || s_win !== prev_win || s_last !== prev_last) begin
                    errors++;
                    $display("FAIL gaps_hold: got valid=%b last=%b [%s], expected 1 %b [%s]",
                             s_valid, s_last, win_str(s_win), prev_last, win_str(prev_win));
                end
            end
            prev_stall = s_valid && !ordy;
            prev_win   = s_win;
            prev_last  = s_last;
            if (s_hs) begin
                checks++;
                if (!s_exp_ok || s_win !== s_exp_win || s_last !== s_exp_last) begin
                    errors++;
                    $display("FAIL gaps_window %0d: got [%s] last=%b, expected [%s] last=%b queued=%b",
                             nwin, win_str(s_win), s_last, win_str(s_exp_win), s_exp_last, s_exp_ok);
                end
                nwin++;
            end
            if (s_acc) sent++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL gaps_timeout: sent %0d of %0d", sent, N_ELEM);
        end
        checks++;
        if (nwin != N_WIN) begin
            errors++;
            $display("FAIL gaps_count: got %0d windows, expected %0d", nwin, N_WIN);
        end
    endtask

    task automatic test_back_to_back;
        test_stream(2, 1'b1, "b2b");
    endtask

    task automatic test_reset_mid;
        int sent = 0, nwin = 0;
        step(1'b0, '0, 1'b1, 1'b1);
        for (int cyc = 0; cyc < N_ELEM && sent <= 100; cyc++) begin
            step(1'b1, DATA_W'(sent), 1'b1, 1'b0);
            if (s_hs) begin
                checks++;
                if (!s_exp_ok || s_win !== s_exp_win || s_last !== s_exp_last) begin
                    errors++;
                    $display("FAIL rstmid_window %0d: got [%s], expected [%s] queued=%b",
                             nwin, win_str(s_win), win_str(s_exp_win), s_exp_ok);
                end
                nwin++;
            end
            if (s_acc) sent++;
        end
        // Element 100 sits at (7,2), so its window is pending when reset hits.
        step(1'b1, DATA_W'(sent), 1'b1, 1'b1);
        checks++;
        if (s_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pending: got valid=%b, expected 1", s_valid);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (s_valid !== 1'b0 || s_last !== 1'b0 || s_win !== '0) begin
            errors++;
            $display("FAIL rstmid_cleared: got valid=%b last=%b [%s], expected 0 0 zero",
                     s_valid, s_last, win_str(s_win));
        end
        test_stream(1, 1'b0, "restart");
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        m_pos         = 0;
        @(posedge clk);
        #1;
        test_reset;
        test_stream(1, 1'b1, "stream");
        test_stall;
        test_gaps;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
